alu_execute: RTL and testbench

Execute stage of the RV32 integer pipeline, directly downstream of the ALU-control decoder. Consumes the 4-bit ALU operation code plus two operands and the destination register index, computes the result, and holds it in an output register with a valid/ready handshake toward the memory/writeback stage. Shifts are iterative (one bit per cycle) by default to save area, so the block contains a small state machine and applies backpressure upstream while a shift runs.

---
 rtl/alu_execute.sv | 168 ++++++++++++++++
 tb/tb_alu_execute.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_execute.sv
// RV32 execute stage: ALU with registered valid/ready output and an optional 1-bit/cycle shifter.
// Latency 1 edge (non-shift/barrel), shamt+1 edges (serial shift); stalls upstream while shifting or output is blocked.
module alu_execute #(
    parameter int XLEN         = 32,
    parameter bit SHIFT_SERIAL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_decode,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            zero,
    output logic            busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    logic [0:0]      state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_q, rd_d;
    logic            zero_q, zero_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] sh_q, sh_d;
    logic [3:0]      sh_op_q, sh_op_d;
    logic [4:0]      sh_rd_q, sh_rd_d;

    logic            out_free;
    logic            accept;
    logic            is_shift;
    logic            serial_start;
    logic            shift_done;
    logic            write_out;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] wr_res;
    logic [XLEN-1:0] sh_step;

    function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = a << b[4:0];
            OP_SLT:  r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, a < b};
            OP_XOR:  r = a ^ b;
            OP_SRL:  r = a >> b[4:0];
            OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign out_free     = !out_valid_q || out_ready;
    assign in_ready     = reset && (state_q == IDLE) && out_free;
    assign accept       = in_valid && in_ready;
    assign is_shift     = (alu_decode == OP_SLL) || (alu_decode == OP_SRL) || (alu_decode == OP_SRA);
    assign serial_start = accept && SHIFT_SERIAL && is_shift;
    assign shift_done   = (state_q == SHIFT) && (cnt_q == 5'd0) && out_free;
    assign write_out    = (accept && !serial_start) || shift_done;
    assign alu_res      = alu_f(alu_decode, op_a, op_b);
    assign wr_res       = shift_done ? sh_q : alu_res;

    always_comb begin
        case (sh_op_q)
            OP_SLL:  sh_step = {sh_q[XLEN-2:0], 1'b0};
            OP_SRL:  sh_step = {1'b0, sh_q[XLEN-1:1]};
            default: sh_step = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        rd_d        = rd_q;
        zero_d      = zero_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        sh_op_d     = sh_op_q;
        sh_rd_d     = sh_rd_q;

        // A new result on a handshake edge replaces the one being consumed.
        if (write_out) begin
            out_valid_d = 1'b1;
            result_d    = wr_res;
            rd_d        = shift_done ? sh_rd_q : rd_in;
            zero_d      = (wr_res == '0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (serial_start) begin
                    state_d = SHIFT;
                    sh_d    = op_a;
                    cnt_d   = op_b[4:0];
                    sh_op_d = alu_decode;
                    sh_rd_d = rd_in;
                end
            end
            default: begin
                if (cnt_q != 5'd0) begin
                    sh_d  = sh_step;
                    cnt_d = cnt_q - 5'd1;
                end else if (out_free) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
            zero_q      <= 1'b0;
            cnt_q       <= '0;
            sh_q        <= '0;
            sh_op_q     <= '0;
            sh_rd_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            zero_q      <= zero_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            sh_op_q     <= sh_op_d;
            sh_rd_q     <= sh_rd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign rd_out    = rd_q;
    assign zero      = zero_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_execute.sv
// Bench for alu_execute: serial-shift and barrel-shift instances against an arithmetic reference and an ordered scoreboard.
module tb_alu_execute;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // serial-shift instance
    logic        s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0, s_zero, s_busy;
    logic [3:0]  s_alu_decode = 0;
    logic [31:0] s_op_a = 0, s_op_b = 0, s_result;
    logic [4:0]  s_rd_in = 0, s_rd_out;

    // barrel-shift instance
    logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_zero, b_busy;
    logic [3:0]  b_alu_decode = 0;
    logic [31:0] b_op_a = 0, b_op_b = 0, b_result;
    logic [4:0]  b_rd_in = 0, b_rd_out;

    alu_execute #(.XLEN(32), .SHIFT_SERIAL(1'b1)) u_ser (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .alu_decode(s_alu_decode), .op_a(s_op_a), .op_b(s_op_b), .rd_in(s_rd_in),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
        .rd_out(s_rd_out), .zero(s_zero), .busy(s_busy));

    alu_execute #(.XLEN(32), .SHIFT_SERIAL(1'b0)) u_bar (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .alu_decode(b_alu_decode), .op_a(b_op_a), .op_b(b_op_b), .rd_in(b_rd_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result),
        .rd_out(b_rd_out), .zero(b_zero), .busy(b_busy));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7:    return $unsigned($signed(a) >>> sh);
            4'd8:    return a | b;
            4'd9:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ordered scoreboard on the serial instance, sampled on the falling edge.
    typedef struct { logic [31:0] r; logic [4:0] rd; } exp_t;
    exp_t sb[$];
    logic        hold_v = 0;
    logic [31:0] hold_r = 0;
    logic [4:0]  hold_rd = 0;

    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            hold_v = 0;
        end else begin
            if (hold_v) begin
                chk("hold_vld", {31'd0, s_out_valid}, 32'd1);
                chk("hold_res", s_result, hold_r);
                chk("hold_rd", {27'd0, s_rd_out}, {27'd0, hold_rd});
            end
            if (s_out_valid && s_out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", {31'd0, s_out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_res", s_result, e.r);
                    chk("sb_rd", {27'd0, s_rd_out}, {27'd0, e.rd});
                    chk("sb_zero", {31'd0, s_zero}, (e.r == 0) ? 32'd1 : 32'd0);
                end
            end
            if (s_in_valid && s_in_ready) begin
                exp_t e;
                e.r  = ref_alu(s_alu_decode, s_op_a, s_op_b);
                e.rd = s_rd_in;
                sb.push_back(e);
            end
            hold_v  = s_out_valid && !s_out_ready;
            hold_r  = s_result;
            hold_rd = s_rd_out;
        end
    end

    task automatic s_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        chk("pre_rdy", {31'd0, s_in_ready}, 32'd1);
        s_in_valid = 1; s_alu_decode = op; s_op_a = a; s_op_b = b; s_rd_in = rd;
        step();
        s_in_valid = 0;
    endtask

    task automatic s_res(input string tag, input logic [31:0] r, input logic z);
        chk({tag, "_vld"}, {31'd0, s_out_valid}, 32'd1);
        chk({tag, "_res"}, s_result, r);
        chk({tag, "_zero"}, {31'd0, s_zero}, {31'd0, z});
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'h8000_0000;
            2: v = 32'h7FFF_FFFF;
            3: v = 32'hFFFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        // reset state
        repeat (3) step();
        chk("rst_vld", {31'd0, s_out_valid}, 32'd0);
        chk("rst_res", s_result, 32'd0);
        chk("rst_rd", {27'd0, s_rd_out}, 32'd0);
        chk("rst_zero", {31'd0, s_zero}, 32'd0);
        chk("rst_busy", {31'd0, s_busy}, 32'd0);
        chk("rst_rdy", {31'd0, s_in_ready}, 32'd0);
        reset = 1; s_out_ready = 1;
        step();

        // basic arithmetic, back to back
        s_op(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd5);
        s_res("add", 32'h8000_0000, 1'b0);
        chk("add_rd", {27'd0, s_rd_out}, 32'd5);
        s_op(4'd1, 32'd5, 32'd5, 5'd6);
        s_res("sub", 32'd0, 1'b1);
        s_op(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd7);
        s_res("slt", 32'd1, 1'b0);
        s_op(4'd4, 32'hFFFF_FFFF, 32'd1, 5'd8);
        s_res("sltu", 32'd0, 1'b1);
        s_op(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9);
        s_res("rsvd", 32'd0, 1'b1);

        // serial SRA, shamt 4 with upper bits set
        s_op(4'd7, 32'h8000_0000, 32'h24, 5'd10);
        for (int k = 0; k < 5; k++) begin
            chk("sra_busy", {31'd0, s_busy}, 32'd1);
            chk("sra_rdy", {31'd0, s_in_ready}, 32'd0);
            chk("sra_vld", {31'd0, s_out_valid}, 32'd0);
            step();
        end
        s_res("sra", 32'hF800_0000, 1'b0);
        chk("sra_busy_end", {31'd0, s_busy}, 32'd0);

        // SLL by 0 completes one edge after accept
        s_op(4'd2, 32'd1, 32'd0, 5'd11);
        chk("sll0_vld", {31'd0, s_out_valid}, 32'd0);
        step();
        s_res("sll0", 32'd1, 1'b0);
        step();

        // backpressure
        s_out_ready = 0;
        s_op(4'd0, 32'd1, 32'd1, 5'd1);
        s_res("bp1", 32'd2, 1'b0);
        s_in_valid = 1; s_alu_decode = 4'd0; s_op_a = 32'd2; s_op_b = 32'd2; s_rd_in = 5'd2;
        for (int k = 0; k < 3; k++) begin
            chk("bp_rdy", {31'd0, s_in_ready}, 32'd0);
            step();
            s_res("bp_hold", 32'd2, 1'b0);
        end
        s_out_ready = 1;
        step();
        s_in_valid = 0;
        s_res("bp2", 32'd4, 1'b0);
        chk("bp2_rd", {27'd0, s_rd_out}, 32'd2);
        step();

        // reset in the middle of a long shift
        s_op(4'd2, 32'hDEAD_BEEF, 32'd31, 5'd3);
        repeat (10) step();
        chk("mid_busy", {31'd0, s_busy}, 32'd1);
        reset = 0;
        step();
        chk("mrst_vld", {31'd0, s_out_valid}, 32'd0);
        chk("mrst_busy", {31'd0, s_busy}, 32'd0);
        chk("mrst_res", s_result, 32'd0);
        reset = 1;
        #1;
        chk("mrst_rdy", {31'd0, s_in_ready}, 32'd1);
        for (int k = 0; k < 30; k++) begin
            step();
            chk("no_stale", {31'd0, s_out_valid}, 32'd0);
        end

        // randomized traffic with random downstream stalls
        for (int k = 0; k < 600; k++) begin
            s_in_valid   = ($urandom_range(0, 1) == 1);
            s_alu_decode = 4'($urandom_range(0, 15));
            s_op_a       = pick_val();
            s_op_b       = ($urandom_range(0, 1) == 1) ? pick_val() : 32'($urandom_range(0, 40));
            s_rd_in      = 5'($urandom_range(0, 31));
            s_out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        s_in_valid = 0; s_out_ready = 1;
        repeat (40) step();
        chk("sb_drained", sb.size(), 32'd0);

        // barrel build: same latency as ALU ops, one shift per cycle
        b_in_valid = 1; b_alu_decode = 4'd6; b_op_a = 32'h8000_0000; b_op_b = 32'd31; b_rd_in = 5'd4;
        chk("bar_rdy0", {31'd0, b_in_ready}, 32'd1);
        step();
        chk("bar_srl_vld", {31'd0, b_out_valid}, 32'd1);
        chk("bar_srl", b_result, 32'd1);
        for (int k = 0; k < 150; k++) begin
            logic [31:0] e;
            logic [4:0]  erd;
            b_alu_decode = ($urandom_range(0, 1) == 1) ? 4'(2 + 4 * $urandom_range(0, 1) + $urandom_range(0, 1))
                                                        : 4'($urandom_range(0, 15));
            b_op_a  = pick_val();
            b_op_b  = $urandom;
            b_rd_in = 5'($urandom_range(0, 31));
            e   = ref_alu(b_alu_decode, b_op_a, b_op_b);
            erd = b_rd_in;
            chk("bar_rdy", {31'd0, b_in_ready}, 32'd1);
            step();
            chk("bar_vld", {31'd0, b_out_valid}, 32'd1);
            chk("bar_res", b_result, e);
            chk("bar_rd", {27'd0, b_rd_out}, {27'd0, erd});
            chk("bar_zero", {31'd0, b_zero}, (e == 0) ? 32'd1 : 32'd0);
        end
        b_in_valid = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
